apb_rr_arbiter: RTL
===================

APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, APB address width.
REQ-002 Parameter DATA_W, default 32, APB data width.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS cycles before forced termination; legal range 2..255.
REQ-004 pclk  in  1  APB clock; all state changes on rising edge.
REQ-005 preset  in  1  asynchronous, active-high reset.
REQ-006 req_valid_i  in  2  per-requester transfer request; bit n = requester n.
REQ-007 req_write_i  in  2  per-requester direction; 1 = write, 0 = read.
REQ-008 req_addr_i  in  2*ADDR_W  requester n address in bits [n*ADDR_W +: ADDR_W].
REQ-009 req_wdata_i  in  2*DATA_W  requester n write data in bits [n*DATA_W +: DATA_W].
REQ-010 rsp_done_o  out  2  registered one-cycle completion pulse to the served requester.
REQ-011 rsp_rdata_o  out  DATA_W  read data of the last completed transfer.
REQ-012 rsp_slverr_o  out  1  error flag of the last completed transfer.
REQ-013 grant_o  out  2  one-hot current owner; 00 in IDLE.
REQ-014 psel_o, penable_o, pwrite_o  out  1 each  APB master controls.
REQ-015 paddr_o  out  ADDR_W  APB address; pwdata_o  out  DATA_W  APB write data.
REQ-016 prdata_i  in  DATA_W; pready_i  in  1; pslverr_i  in  1  APB slave response.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, SETUP and ACCESS.
REQ-018 Requesters SHALL hold valid, write, addr and wdata stable from assertion until the cycle they see rsp_done_o, and SHALL drop valid on the following edge.
REQ-019 IDLE: the effective request is req_valid_i & ~rsp_done_o (the requester being acknowledged is masked). With no effective request, the FSM stays in IDLE.
REQ-020 IDLE with one effective request: grant it. With two: grant the requester not equal to last_grant. Then go to SETUP and latch paddr_o/pwrite_o/pwdata_o from the granted requester.
REQ-021 SETUP: psel_o=1, penable_o=0. Unconditionally go to ACCESS on the next edge.
REQ-022 ACCESS: psel_o=1, penable_o=1. paddr/pwrite/pwdata SHALL be stable from SETUP through the end of ACCESS.
REQ-023 ACCESS with pready_i=1: go to IDLE; next cycle assert rsp_done_o[grant] for one cycle. rsp_rdata_o = prdata_i for reads, 0 for writes; rsp_slverr_o = pslverr_i.
REQ-024 Wait counter: cleared on SETUP entry; increments on each ACCESS cycle with pready_i=0.
REQ-025 If ACCESS has pready_i=0 while the counter equals TIMEOUT-1, the transfer SHALL terminate as in REQ-023, except rsp_rdata_o=0 and rsp_slverr_o=1.
REQ-026 last_grant SHALL update to the served requester at completion, including timeout completion.
REQ-027 rsp_rdata_o and rsp_slverr_o SHALL hold their values until the next completion.
REQ-028 The minimum transfer takes 3 cycles (SETUP, ACCESS, IDLE). A new SETUP never directly follows ACCESS.
REQ-029 grant_o SHALL equal the latched owner in SETUP/ACCESS and 00 in IDLE.
REQ-030 Requests that arrive or drop during SETUP/ACCESS SHALL NOT affect the transfer in progress.

Reset
REQ-031 On preset=1 all outputs SHALL clear immediately (asynchronously) to 0: psel, penable, pwrite, paddr, pwdata, grant, rsp_done, rsp_rdata, rsp_slverr.
REQ-032 On reset, state=IDLE, counter=0 and last_grant=1, so requester 0 wins the first tie.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer with no rsp_done_o pulse. The first grant after reset release follows REQ-020.

Verification
REQ-034 Single write: req0 write, addr 0x03, data 0x1234ABCD, pready=1 in ACCESS -> SETUP then ACCESS with paddr=0x03, pwdata=0x1234ABCD, pwrite=1; rsp_done_o=01 two cycles after SETUP; slverr=0.
REQ-035 Read with wait states: req1 read, addr 0x01, pready low for 3 ACCESS cycles then high with prdata=0x5678EF01 -> penable high for 4 cycles; rsp_done_o=10; rsp_rdata_o=0x5678EF01.
REQ-036 Tie after reset: both requesters valid together -> req0 served first, then req1. Repeat both valid -> req0 then req1 again (alternation); no IDLE-cycle regrant to the just-acknowledged requester.
REQ-037 Timeout: TIMEOUT=16, pready held 0 -> exactly 16 ACCESS cycles, then rsp_done pulse with rsp_slverr_o=1 and rsp_rdata_o=0; FSM back in IDLE.
REQ-038 Slave error: pslverr_i=1 with pready_i=1 -> rsp_slverr_o=1; the next clean transfer clears it to 0.
REQ-039 Reset mid-ACCESS: preset pulsed during ACCESS of req0 -> psel/penable drop to 0 without a clock edge; no rsp_done_o pulse; req0 still valid after release -> regranted, transfer completes normally.

Source files
------------

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: two-requester round-robin front end for a single APB master port.
// Serves one transfer at a time through IDLE -> SETUP -> ACCESS. A transfer ends
// on pready_i, or is forced to end with an error when the slave stalls too long.
module apb_rr_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic [1:0]            req_valid_i,
    input  logic [1:0]            req_write_i,
    input  logic [2*ADDR_W-1:0]   req_addr_i,
    input  logic [2*DATA_W-1:0]   req_wdata_i,
    output logic [1:0]            rsp_done_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_slverr_o,
    output logic [1:0]            grant_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_W-1:0]     paddr_o,
    output logic [DATA_W-1:0]     pwdata_o,
    input  logic [DATA_W-1:0]     prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               owner;
    logic               last_grant;

    logic [1:0]         eff_req;
    logic               pick;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_write;
    logic               finish_ok;
    logic               finish_to;

    // Effective requests: the requester acknowledged this cycle is still valid but must not be regranted.
    assign eff_req = req_valid_i & ~rsp_done_o;

    // Round-robin pick: a lone request wins; on a tie the requester not served last wins.
    always_comb begin
        pick = 1'b0;
        case (eff_req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_grant;
            default: pick = 1'b0;
        endcase
    end

    // Payload of the picked requester, latched on the IDLE -> SETUP edge.
    always_comb begin
        sel_addr  = pick ? req_addr_i[2*ADDR_W-1:ADDR_W]  : req_addr_i[ADDR_W-1:0];
        sel_wdata = pick ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];
        sel_write = req_write_i[pick];
    end

    // ACCESS ends normally on pready, or by timeout when the slave has stalled TIMEOUT cycles.
    assign finish_ok = (state == ACCESS) && pready_i;
    assign finish_to = (state == ACCESS) && !pready_i && (wait_cnt == CNT_LAST);

    // Transfer FSM with all APB and response outputs registered.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            grant_o      <= 2'b00;
            psel_o       <= 1'b0;
            penable_o    <= 1'b0;
            pwrite_o     <= 1'b0;
            paddr_o      <= '0;
            pwdata_o     <= '0;
            rsp_done_o   <= 2'b00;
            rsp_rdata_o  <= '0;
            rsp_slverr_o <= 1'b0;
        end else begin
            rsp_done_o <= 2'b00;
            case (state)
                IDLE: begin
                    if (eff_req != 2'b00) begin
                        state     <= SETUP;
                        owner     <= pick;
                        grant_o   <= pick ? 2'b10 : 2'b01;
                        psel_o    <= 1'b1;
                        penable_o <= 1'b0;
                        paddr_o   <= sel_addr;
                        pwdata_o  <= sel_wdata;
                        pwrite_o  <= sel_write;
                        wait_cnt  <= '0;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    penable_o <= 1'b1;
                end
                ACCESS: begin
                    if (finish_ok || finish_to) begin
                        state      <= IDLE;
                        psel_o     <= 1'b0;
                        penable_o  <= 1'b0;
                        grant_o    <= 2'b00;
                        rsp_done_o <= grant_o;
                        last_grant <= owner;
                        if (finish_ok) begin
                            rsp_rdata_o  <= pwrite_o ? '0 : prdata_i;
                            rsp_slverr_o <= pslverr_i;
                        end else begin
                            rsp_rdata_o  <= '0;
                            rsp_slverr_o <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    psel_o    <= 1'b0;
                    penable_o <= 1'b0;
                    grant_o   <= 2'b00;
                end
            endcase
        end
    end

endmodule
